rasterizer_mem_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the rasterizer's single 26-bit memory master between the vertex fetch unit (port 0) and the pixel/framebuffer writer (port 1). It grants one requester at a time with lock-while-requesting, round-robin and a hold limit. It also routes pipelined read responses back to the issuing port through an in-order tag FIFO. It sits between the rasterizer units and the SDRAM-side interconnect.

---
 rtl/rasterizer_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rasterizer_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rasterizer_mem_arbiter.sv
// Shares the rasterizer's single Avalon-MM master between vertex fetch (port 0) and pixel writer (port 1).
// Define RASTER_ARB_FIXED_PRIORITY_EN for fixed port-0 priority with no hold-limit preemption.
module rasterizer_mem_arbiter #(
  parameter int ADDR_W         = 26,
  parameter int TAG_DEPTH_LOG2 = 4,
  parameter int MAX_HOLD       = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [3:0]        s0_byteenable,
  input  logic [31:0]       s0_writedata,
  output logic              s0_waitrequest,
  output logic [31:0]       s0_readdata,
  output logic              s0_readdatavalid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [3:0]        s1_byteenable,
  input  logic [31:0]       s1_writedata,
  output logic              s1_waitrequest,
  output logic [31:0]       s1_readdata,
  output logic              s1_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest,
  output logic              err_orphan
);

  localparam int TAG_DEPTH = 1 << TAG_DEPTH_LOG2;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P0   = 2'd1;
  localparam logic [1:0] OWN_P1   = 2'd2;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [TAG_DEPTH_LOG2:0] TAG_FULL_COUNT = {1'b1, {TAG_DEPTH_LOG2{1'b0}}};
  localparam logic [TAG_DEPTH_LOG2:0] COUNT_ONE = {{TAG_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [TAG_DEPTH_LOG2-1:0] PTR_ONE = {{(TAG_DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [1:0] owner, owner_next;
  logic       rr_last;
  logic [7:0] hold;
  logic       req0, req1;
  logic       owned, sel1;
  logic       own_read, own_write, own_req;
  logic       read_blocked;
  logic       accepted, grant;
  logic       hold_release, tie_pick1;

  logic [TAG_DEPTH-1:0]      tag_mem;
  logic [TAG_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TAG_DEPTH_LOG2:0]   tag_count, tag_count_next;
  logic                      tag_full, tag_empty;
  logic                      push, pop, head;

  assign req0      = s0_read | s0_write;
  assign req1      = s1_read | s1_write;
  assign owned     = owner != OWN_NONE;
  assign sel1      = owner == OWN_P1;
  assign own_read  = sel1 ? s1_read : s0_read;
  assign own_write = sel1 ? s1_write : s0_write;
  assign own_req   = owned & (sel1 ? req1 : req0);

  // Only reads consume a tag slot, so a full FIFO never stalls a write.
  assign read_blocked = tag_full & own_read;

  assign m_address    = sel1 ? s1_address : s0_address;
  assign m_byteenable = sel1 ? s1_byteenable : s0_byteenable;
  assign m_writedata  = sel1 ? s1_writedata : s0_writedata;
  assign m_read       = owned & own_read & ~tag_full;
  assign m_write      = owned & own_write;

  assign accepted = (m_read | m_write) & ~m_waitrequest;
  assign push     = m_read & ~m_waitrequest;
  assign tag_empty = tag_count == '0;
  assign pop      = m_readdatavalid & ~tag_empty;
  assign head     = tag_mem[rd_ptr];

  assign s0_waitrequest   = (owner != OWN_P0) | m_waitrequest | read_blocked;
  assign s1_waitrequest   = (owner != OWN_P1) | m_waitrequest | read_blocked;
  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = pop & ~head;
  assign s1_readdatavalid = pop & head;

`ifdef RASTER_ARB_FIXED_PRIORITY_EN
  assign hold_release = 1'b0;
  assign tie_pick1    = 1'b0;
`else
  // Release only on an accepted beat so a transfer is never cut in half.
  assign hold_release = accepted & (sel1 ? req0 : req1) & (hold >= HOLD_LIMIT - 8'd1);
  assign tie_pick1    = ~rr_last;
`endif

  always_comb begin
    owner_next = owner;
    case (owner)
      OWN_NONE: begin
        if (req0 & req1)
          owner_next = tie_pick1 ? OWN_P1 : OWN_P0;
        else if (req0)
          owner_next = OWN_P0;
        else if (req1)
          owner_next = OWN_P1;
      end
      OWN_P0, OWN_P1: begin
        if (!own_req || hold_release)
          owner_next = OWN_NONE;
      end
      default: owner_next = OWN_NONE;
    endcase
  end

  assign grant = (owner == OWN_NONE) & (owner_next != OWN_NONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner   <= OWN_NONE;
      rr_last <= 1'b1;
      hold    <= 8'd0;
    end else begin
      owner <= owner_next;
      if (grant) begin
        rr_last <= owner_next == OWN_P1;
        hold    <= 8'd0;
      end else if (accepted && hold < HOLD_LIMIT) begin
        hold <= hold + 8'd1;
      end
    end
  end

  always_comb begin
    tag_count_next = tag_count;
    case ({push, pop})
      2'b10:   tag_count_next = tag_count + COUNT_ONE;
      2'b01:   tag_count_next = tag_count - COUNT_ONE;
      default: tag_count_next = tag_count;
    endcase
  end

  // Full is registered: a pop in the full cycle unblocks reads only on the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      tag_full   <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      tag_count <= tag_count_next;
      tag_full  <= tag_count_next == TAG_FULL_COUNT;
      if (m_readdatavalid && tag_empty)
        err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      tag_mem[wr_ptr] <= sel1;
  end

endmodule

// File: tb/tb_rasterizer_mem_arbiter.sv
// Self-checking bench for rasterizer_mem_arbiter: port masters, a delayable memory model and a response scoreboard.
// Honours RASTER_ARB_FIXED_PRIORITY_EN when choosing expected arbitration results.
module tb_rasterizer_mem_arbiter;

  localparam int ADDR_W = 26;
  localparam int HOLD   = 4;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] s0_address, s1_address;
  logic              s0_read, s0_write, s1_read, s1_write;
  logic [3:0]        s0_byteenable, s1_byteenable;
  logic [31:0]       s0_writedata, s1_writedata;
  logic              s0_waitrequest, s1_waitrequest;
  logic [31:0]       s0_readdata, s1_readdata;
  logic              s0_readdatavalid, s1_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata;
  logic              m_readdatavalid;
  logic              m_waitrequest;
  logic              err_orphan;

  int tests_run;
  int tests_failed;
  logic [32:0]       sb[$];
  logic [ADDR_W-1:0] pend[$];
  int   left0, left1;
  bit   wr0, wr1;
  int   acc0_count, acc1_count, v0_count, v1_count;
  logic [15:0] order_log;
  bit   mem_hold;
  int   resp_budget;
  bit   exp_p1_first;

  rasterizer_mem_arbiter #(
    .ADDR_W(ADDR_W),
    .TAG_DEPTH_LOG2(4),
    .MAX_HOLD(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s0_address(s0_address),
    .s0_read(s0_read),
    .s0_write(s0_write),
    .s0_byteenable(s0_byteenable),
    .s0_writedata(s0_writedata),
    .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address),
    .s1_read(s1_read),
    .s1_write(s1_write),
    .s1_byteenable(s1_byteenable),
    .s1_writedata(s1_writedata),
    .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address),
    .m_read(m_read),
    .m_write(m_write),
    .m_byteenable(m_byteenable),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest),
    .err_orphan(err_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'(a) ^ 32'h5A3C_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input bit is_write, input int count, input logic [ADDR_W-1:0] base);
    if (port == 0) begin
      left0 = count; wr0 = is_write;
      s0_address = base; s0_writedata = mem_word(base); s0_byteenable = 4'hF;
      s0_read = !is_write && count > 0; s0_write = is_write && count > 0;
    end else begin
      left1 = count; wr1 = is_write;
      s1_address = base; s1_writedata = mem_word(base); s1_byteenable = 4'h3;
      s1_read = !is_write && count > 0; s1_write = is_write && count > 0;
    end
    #1;
  endtask

  task automatic clearCounts();
    acc0_count = 0; acc1_count = 0; v0_count = 0; v1_count = 0; order_log = '0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    left0 = 0; left1 = 0;
    s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
    mem_hold = 1'b0; resp_budget = 0;
    sb.delete();
    clearCounts();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
  endtask

  // One clock: sample handshakes at negedge, advance masters and memory just after posedge.
  task automatic tick();
    bit a0, a1, macc;
    logic [32:0] entry;
    @(negedge clock);
    a0   = (s0_read | s0_write) & ~s0_waitrequest;
    a1   = (s1_read | s1_write) & ~s1_waitrequest;
    macc = m_read & ~m_waitrequest;
    if (s0_readdatavalid || s1_readdatavalid) begin
      checkOutput("valid_onehot", 32'(s0_readdatavalid & s1_readdatavalid), 32'd0);
      if (s0_readdatavalid) v0_count++;
      if (s1_readdatavalid) v1_count++;
      order_log = {order_log[14:0], s1_readdatavalid};
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        entry = sb.pop_front();
        checkOutput("resp_port", 32'(s1_readdatavalid), 32'(entry[32]));
        checkOutput("resp_data0", s0_readdata, entry[31:0]);
        checkOutput("resp_data1", s1_readdata, entry[31:0]);
      end
    end else if (m_readdatavalid && sb.size() != 0) begin
      checkOutput("missing_valid", 32'd0, 32'd1);
    end
    if (a0) begin
      acc0_count++;
      if (s0_read) sb.push_back({1'b0, mem_word(s0_address)});
    end
    if (a1) begin
      acc1_count++;
      if (s1_read) sb.push_back({1'b1, mem_word(s1_address)});
    end
    if (macc) pend.push_back(m_address);
    @(posedge clock);
    #1;
    if (a0) begin left0--; s0_address++; s0_writedata = mem_word(s0_address); end
    if (a1) begin left1--; s1_address++; s1_writedata = mem_word(s1_address); end
    s0_read = left0 > 0 && !wr0; s0_write = left0 > 0 && wr0;
    s1_read = left1 > 0 && !wr1; s1_write = left1 > 0 && wr1;
    if (pend.size() > 0 && (!mem_hold || resp_budget > 0)) begin
      m_readdatavalid = 1'b1;
      m_readdata = mem_word(pend.pop_front());
      if (mem_hold) resp_budget--;
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    for (int i = 0; i < budget && (left0 > 0 || left1 > 0 || sb.size() > 0 || pend.size() > 0); i++)
      tick();
    checkOutput(tag, 32'(left0 == 0 && left1 == 0 && sb.size() == 0 && pend.size() == 0), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
    s0_byteenable = 4'hF; s1_byteenable = 4'h3;
    m_readdata = '0;
`ifdef RASTER_ARB_FIXED_PRIORITY_EN
    exp_p1_first = 1'b0;
`else
    exp_p1_first = 1'b1;
`endif

    reset = 1'b0;
    s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checkOutput("rst_s0_wait", 32'(s0_waitrequest), 32'd1);
    checkOutput("rst_s1_wait", 32'(s1_waitrequest), 32'd1);
    checkOutput("rst_m_rw", 32'({m_read, m_write}), 32'd0);
    checkOutput("rst_valids", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
    checkOutput("rst_orphan", 32'(err_orphan), 32'd0);

    // Single port, 15 back-to-back reads.
    applyReset();
    applyStimulus(0, 1'b0, 15, 26'h100);
    checkOutput("t1_pre_grant", 32'(s0_waitrequest), 32'd1);
    tick();
    checkOutput("t1_grant_wait", 32'(s0_waitrequest), 32'd0);
    checkOutput("t1_grant_read", 32'(m_read), 32'd1);
    checkOutput("t1_grant_addr", 32'(m_address), 32'h100);
    checkOutput("t1_s1_wait", 32'(s1_waitrequest), 32'd1);
    runUntilIdle("t1_idle", 100);
    checkOutput("t1_accepts", 32'(acc0_count), 32'd15);
    checkOutput("t1_v0", 32'(v0_count), 32'd15);
    checkOutput("t1_v1", 32'(v1_count), 32'd0);

    // Simultaneous writes after reset, then round-robin tie.
    applyReset();
    applyStimulus(0, 1'b1, 3, 26'h200);
    applyStimulus(1, 1'b1, 3, 26'h300);
    checkOutput("t2_idle_wait", 32'({s0_waitrequest, s1_waitrequest}), 32'd3);
    tick();
    checkOutput("t2_p0_first", 32'({s0_waitrequest, s1_waitrequest}), 32'b01);
    checkOutput("t2_m_write", 32'(m_write), 32'd1);
    checkOutput("t2_m_addr", 32'(m_address), 32'h200);
    checkOutput("t2_m_wdata", m_writedata, mem_word(26'h200));
    checkOutput("t2_m_be", 32'(m_byteenable), 32'hF);
    repeat (4) tick();
    checkOutput("t2_handoff_none", 32'({s0_waitrequest, s1_waitrequest}), 32'd3);
    checkOutput("t2_handoff_nowr", 32'(m_write), 32'd0);
    tick();
    checkOutput("t2_p1_grant", 32'({s0_waitrequest, s1_waitrequest}), 32'b10);
    checkOutput("t2_p1_addr", 32'(m_address), 32'h300);
    checkOutput("t2_p1_be", 32'(m_byteenable), 32'h3);
    runUntilIdle("t2_idle", 30);
    applyStimulus(0, 1'b1, 1, 26'h400);
    runUntilIdle("t2_solo_idle", 30);
    applyStimulus(0, 1'b1, 2, 26'h500);
    applyStimulus(1, 1'b1, 2, 26'h600);
    tick();
    checkOutput("t2_tie2_s1", 32'(s1_waitrequest), 32'(!exp_p1_first));
    checkOutput("t2_tie2_s0", 32'(s0_waitrequest), 32'(exp_p1_first));
    runUntilIdle("t2_tie2_idle", 40);

    // Hold limit: s0 streams writes while s1 waits.
    applyReset();
    applyStimulus(0, 1'b1, 40, 26'h1000);
    applyStimulus(1, 1'b1, 3, 26'h2000);
    repeat (4) tick();
    checkOutput("t3_acc_before", 32'(acc0_count), 32'd3);
    checkOutput("t3_s0_owned", 32'(s0_waitrequest), 32'd0);
    tick();
`ifdef RASTER_ARB_FIXED_PRIORITY_EN
    checkOutput("t3_keep_s0", 32'({s0_waitrequest, s1_waitrequest}), 32'b01);
    repeat (15) tick();
    checkOutput("t3_keep_acc", 32'(acc0_count), 32'd19);
    checkOutput("t3_keep_s1", 32'(s1_waitrequest), 32'd1);
`else
    checkOutput("t3_release", 32'({s0_waitrequest, s1_waitrequest}), 32'd3);
    checkOutput("t3_acc_at_release", 32'(acc0_count), 32'd4);
    tick();
    checkOutput("t3_p1_grant", 32'({s0_waitrequest, s1_waitrequest}), 32'b10);
`endif
    left0 = 0; s0_write = 1'b0;
    runUntilIdle("t3_idle", 60);
    checkOutput("t3_s1_acc", 32'(acc1_count), 32'd3);

    // Outstanding overflow with responses held back.
    applyReset();
    mem_hold = 1'b1;
    applyStimulus(0, 1'b0, 20, 26'h3000);
    repeat (25) tick();
    checkOutput("t4_acc_full", 32'(acc0_count), 32'd16);
    checkOutput("t4_full_wait", 32'(s0_waitrequest), 32'd1);
    checkOutput("t4_full_noread", 32'(m_read), 32'd0);
    resp_budget = 1;
    tick();
    checkOutput("t4_pop_valid", 32'(s0_readdatavalid), 32'd1);
    checkOutput("t4_pop_still_wait", 32'(s0_waitrequest), 32'd1);
    checkOutput("t4_pop_noread", 32'(m_read), 32'd0);
    tick();
    checkOutput("t4_unblock_wait", 32'(s0_waitrequest), 32'd0);
    checkOutput("t4_unblock_read", 32'(m_read), 32'd1);
    tick();
    checkOutput("t4_acc_17", 32'(acc0_count), 32'd17);
    checkOutput("t4_full_again", 32'(s0_waitrequest), 32'd1);
    mem_hold = 1'b0;
    runUntilIdle("t4_idle", 100);
    checkOutput("t4_v0", 32'(v0_count), 32'd20);

    // Interleaved owners with outstanding reads.
    applyReset();
    mem_hold = 1'b1;
    applyStimulus(0, 1'b0, 3, 26'h4000);
    applyStimulus(1, 1'b0, 2, 26'h5000);
    for (int i = 0; i < 30 && !(acc0_count == 3 && acc1_count == 2); i++) tick();
    checkOutput("t5_issued", 32'(acc0_count == 3 && acc1_count == 2), 32'd1);
    mem_hold = 1'b0;
    runUntilIdle("t5_idle", 40);
    checkOutput("t5_order", 32'(order_log[4:0]), 32'b00011);
    checkOutput("t5_counts", 32'({v0_count[3:0], v1_count[3:0]}), 32'h32);

    // Reset mid-burst, then the stale responses arrive as orphans.
    applyReset();
    mem_hold = 1'b1;
    applyStimulus(0, 1'b0, 4, 26'h6000);
    for (int i = 0; i < 20 && acc0_count != 4; i++) tick();
    checkOutput("t6_issued", 32'(acc0_count), 32'd4);
    reset = 1'b0;
    left0 = 0; s0_read = 1'b0;
    sb.delete();
    #1;
    checkOutput("t6_rst_wait", 32'({s0_waitrequest, s1_waitrequest}), 32'd3);
    checkOutput("t6_rst_rw", 32'({m_read, m_write}), 32'd0);
    checkOutput("t6_rst_valid", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
    checkOutput("t6_rst_orphan", 32'(err_orphan), 32'd0);
    tick();
    reset = 1'b1;
    mem_hold = 1'b0;
    #1;
    tick();
    checkOutput("t6_orphan_novalid", 32'({s0_readdatavalid, s1_readdatavalid}), 32'd0);
    checkOutput("t6_orphan_pre", 32'(err_orphan), 32'd0);
    tick();
    checkOutput("t6_orphan_set", 32'(err_orphan), 32'd1);
    runUntilIdle("t6_idle", 20);
    checkOutput("t6_orphan_sticky", 32'(err_orphan), 32'd1);
    checkOutput("t6_no_routed", 32'(v0_count + v1_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
